// File: rtl/button_event_scheduler_pkg.sv
// Shared definitions for the button event scheduler: event codes,
// per-button FSM states and width helpers.
package button_event_scheduler_pkg;

  // Event codes; also the bit positions inside each button's pending set
  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HELD     = 2'd1,
    ST_LONGHELD = 2'd2
  } btn_state_t;

  // Width of the event button index; a single button still needs one bit
  function automatic int ev_button_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // Width of the per-button millisecond down-counter
  function automatic int ms_count_width(input int long_ms, input int repeat_ms);
    int max_ms;
    max_ms = (long_ms > repeat_ms) ? long_ms : repeat_ms;
    return (max_ms > 1) ? $clog2(max_ms + 1) : 1;
  endfunction

  // Within one button: PRESS first so a RELEASE can never overtake its PRESS
  function automatic logic [1:0] pick_event(input logic [3:0] pend);
    if (pend[EV_PRESS])       return EV_PRESS;
    else if (pend[EV_LONG])   return EV_LONG;
    else if (pend[EV_REPEAT]) return EV_REPEAT;
    else                      return EV_RELEASE;
  endfunction

endpackage

// File: rtl/button_event_scheduler_fsm.sv
// Per-button event generator: press/hold FSM, millisecond down-counter,
// pending event set and a combinational REPEAT overflow strobe.
//
//   state       | meaning
//   ST_IDLE     | button released (or press deferred while events still pending)
//   ST_HELD     | pressed, counting down to the LONG event
//   ST_LONGHELD | LONG issued, counting down REPEAT intervals
module button_event_fsm
  import button_event_scheduler_pkg::*;
#(
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_level,
  input  logic       i_ms_tick,
  input  logic [3:0] i_grant_clr,
  output logic [3:0] o_pending,
  output logic       o_overflow
);

  localparam int CNT_W = ms_count_width(LONG_PRESS_MS, REPEAT_MS);
  localparam logic [CNT_W-1:0] LONG_LOAD   = CNT_W'(LONG_PRESS_MS);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_MS);

  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_pend;
  logic [3:0]       w_set;
  logic             w_expire;
  logic             w_ovf;

  // A loaded count of zero (REPEAT disabled) never expires
  assign w_expire   = i_ms_tick && (r_cnt == CNT_W'(1));
  assign o_pending  = r_pend;
  assign o_overflow = w_ovf;

  // New events raised this cycle; release has priority over counter expiry
  always_comb begin
    w_set = 4'b0000;
    w_ovf = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_level && (r_pend == 4'b0000)) w_set[EV_PRESS] = 1'b1;
      end
      ST_HELD: begin
        if (!i_level)      w_set[EV_RELEASE] = 1'b1;
        else if (w_expire) w_set[EV_LONG]    = 1'b1;
      end
      ST_LONGHELD: begin
        if (!i_level) begin
          w_set[EV_RELEASE] = 1'b1;
        end else if (w_expire) begin
          w_set[EV_REPEAT] = 1'b1;
          // Only a REPEAT that is not being consumed this cycle is lost
          w_ovf = r_pend[EV_REPEAT] && !i_grant_clr[EV_REPEAT];
        end
      end
      default: ;
    endcase
  end

  // State, counter and pending set; a bit set in the grant cycle survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= 4'b0000;
    end else begin
      r_pend <= (r_pend & ~i_grant_clr) | w_set;
      case (r_state)
        ST_IDLE: begin
          if (w_set[EV_PRESS]) begin
            r_state <= ST_HELD;
            r_cnt   <= LONG_LOAD;
          end
        end
        ST_HELD: begin
          if (!i_level) begin
            r_state <= ST_IDLE;
          end else if (w_expire) begin
            r_state <= ST_LONGHELD;
            r_cnt   <= REPEAT_LOAD;
          end else if (i_ms_tick) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_LONGHELD: begin
          if (!i_level) begin
            r_state <= ST_IDLE;
          end else if (w_expire) begin
            r_cnt <= REPEAT_LOAD;
          end else if (i_ms_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Button event scheduler top: ms prescaler, per-button event FSMs,
// round-robin arbiter, output event register and sticky overflow flag.
module button_event_scheduler
  import button_event_scheduler_pkg::*;
#(
  parameter int CLK_RATE      = -1,
  parameter int BUTTON_COUNT  = 4,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 250
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [BUTTON_COUNT-1:0]                   buttons,
  output logic                                      evValid,
  input  logic                                      evReady,
  output logic [ev_button_width(BUTTON_COUNT)-1:0]  evButton,
  output logic [1:0]                                evType,
  output logic                                      overflow,
  input  logic                                      overflowClear
);

  localparam int EVB_W   = ev_button_width(BUTTON_COUNT);
  localparam int MS_DIV  = CLK_RATE / 1000;
  localparam int DIV_EFF = (MS_DIV < 1) ? 1 : MS_DIV;
  localparam int PRESC_W = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;

  logic [PRESC_W-1:0]    r_presc;
  logic                  w_ms_tick;
  logic [3:0]            w_pend [BUTTON_COUNT];
  logic [3:0]            w_clr  [BUTTON_COUNT];
  logic [BUTTON_COUNT-1:0] w_ovf;
  logic [EVB_W-1:0]      r_rr_next;
  logic                  w_load;
  logic                  w_gnt_found;
  logic [EVB_W-1:0]      w_gnt_idx;
  logic [1:0]            w_gnt_type;
  logic                  w_any_lo, w_any_hi;
  logic [EVB_W-1:0]      w_lo_idx, w_hi_idx;
  logic [1:0]            w_lo_type, w_hi_type;

  assign w_ms_tick = (r_presc == PRESC_W'(DIV_EFF - 1));
  assign w_load    = !evValid || evReady;

  // Free-running millisecond prescaler
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_presc <= '0;
    else if (w_ms_tick) r_presc <= '0;
    else                r_presc <= r_presc + PRESC_W'(1);
  end

  genvar g;
  generate
    for (g = 0; g < BUTTON_COUNT; g++) begin : g_btn
      assign w_clr[g] = (w_load && w_gnt_found && (w_gnt_idx == EVB_W'(g)))
                        ? (4'b0001 << w_gnt_type) : 4'b0000;

      button_event_fsm #(
        .LONG_PRESS_MS (LONG_PRESS_MS),
        .REPEAT_MS     (REPEAT_MS)
      ) u_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_level     (buttons[g]),
        .i_ms_tick   (w_ms_tick),
        .i_grant_clr (w_clr[g]),
        .o_pending   (w_pend[g]),
        .o_overflow  (w_ovf[g])
      );
    end
  endgenerate

  // Round-robin: first pending button at or after r_rr_next, else wrap to lowest
  always_comb begin
    w_any_lo  = 1'b0;
    w_any_hi  = 1'b0;
    w_lo_idx  = '0;
    w_hi_idx  = '0;
    w_lo_type = EV_PRESS;
    w_hi_type = EV_PRESS;
    for (int b = 0; b < BUTTON_COUNT; b++) begin
      if (w_pend[b] != 4'b0000) begin
        if (!w_any_lo) begin
          w_any_lo  = 1'b1;
          w_lo_idx  = EVB_W'(b);
          w_lo_type = pick_event(w_pend[b]);
        end
        if (!w_any_hi && (EVB_W'(b) >= r_rr_next)) begin
          w_any_hi  = 1'b1;
          w_hi_idx  = EVB_W'(b);
          w_hi_type = pick_event(w_pend[b]);
        end
      end
    end
    w_gnt_found = w_any_lo;
    w_gnt_idx   = w_any_hi ? w_hi_idx  : w_lo_idx;
    w_gnt_type  = w_any_hi ? w_hi_type : w_lo_type;
  end

  // Output event register; contents hold while stalled by the consumer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evValid   <= 1'b0;
      evButton  <= '0;
      evType    <= EV_PRESS;
      r_rr_next <= '0;
    end else if (w_load) begin
      evValid <= w_gnt_found;
      if (w_gnt_found) begin
        evButton  <= w_gnt_idx;
        evType    <= w_gnt_type;
        r_rr_next <= (w_gnt_idx == EVB_W'(BUTTON_COUNT - 1)) ? '0 : w_gnt_idx + EVB_W'(1);
      end
    end
  end

  // Sticky overflow; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              overflow <= 1'b0;
    else if (|w_ovf)        overflow <= 1'b1;
    else if (overflowClear) overflow <= 1'b0;
  end

endmodule
